// File: rtl/dec_scan_seq_pkg.sv
// Shared defaults and state type for the decoder scan sequencer.
// Channel count is always 2**SEL_W.
package dec_scan_pkg;
  localparam int SEL_W_DEF   = 4;
  localparam int N_CH_DEF    = 16;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    GAP
  } scan_state_t;
endpackage

// File: rtl/dec_scan_seq_if.sv
// Control/status bundle between a sweep requester and the scan sequencer.
// The sequencer takes the slave side; whoever issues start/stop takes the master side.
interface dec_scan_seq_if
  import dec_scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
);
  localparam int N_CH = 2 ** SEL_W;

  logic               start;
  logic               stop;
  logic [N_CH-1:0]    mask;
  logic [DWELL_W-1:0] dwell;
  logic               continuous;
  logic               en;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               sweep_done;
  logic               cfg_err;

  modport master (
    output start, stop, mask, dwell, continuous,
    input  en, sel, busy, sweep_done, cfg_err
  );

  modport slave (
    input  start, stop, mask, dwell, continuous,
    output en, sel, busy, sweep_done, cfg_err
  );
endinterface

// File: rtl/dec_scan_seq_mask_next_sel.sv
// Combinational channel picker: lowest set bit, next set bit above i_sel,
// and whether i_sel is already the highest set bit.
module mask_next_sel #(
  parameter int SEL_W = 4
) (
  input  logic [2**SEL_W-1:0] i_mask,
  input  logic [SEL_W-1:0]    i_sel,
  output logic [SEL_W-1:0]    o_next_sel,
  output logic                o_is_last,
  output logic [SEL_W-1:0]    o_first_sel
);
  localparam int N_CH = 2 ** SEL_W;

  // Descending scan: the last hit written is the lowest qualifying bit.
  always_comb begin
    o_next_sel  = '0;
    o_is_last   = 1'b1;
    o_first_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_first_sel = SEL_W'(i);
        if (SEL_W'(i) > i_sel) begin
          o_next_sel = SEL_W'(i);
          o_is_last  = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/dec_scan_seq.sv
// Sweeps decoder enable/select over the set bits of a snapshot mask, holding each
// channel for max(dwell,1) cycles with a one-cycle en=0 gap between channels.
module dec_scan_seq
  import dec_scan_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  dec_scan_seq_if.slave bus
);
  localparam int N_CH = 2 ** SEL_W;

  scan_state_t        r_state;
  logic [N_CH-1:0]    r_mask;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_cont;
  logic               r_en;
  logic [SEL_W-1:0]   r_sel;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [N_CH-1:0]    w_mask;
  logic [SEL_W-1:0]   w_next_sel;
  logic [SEL_W-1:0]   w_first_sel;
  logic               w_is_last;

  // In IDLE the picker looks at the live mask so the first channel is ready on start.
  assign w_mask = (r_state == IDLE) ? bus.mask : r_mask;

  mask_next_sel #(.SEL_W(SEL_W)) u_next_sel (
    .i_mask      (w_mask),
    .i_sel       (r_sel),
    .o_next_sel  (w_next_sel),
    .o_is_last   (w_is_last),
    .o_first_sel (w_first_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_cont  <= 1'b0;
      r_en    <= 1'b0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            if (bus.mask == '0) begin
              r_err <= 1'b1;
            end else begin
              r_mask  <= bus.mask;
              r_dwell <= (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
              r_cont  <= bus.continuous;
              r_sel   <= w_first_sel;
              r_cnt   <= DWELL_W'(1);
              r_en    <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= DWELL;
            end
          end
        end
        DWELL: begin
          if (bus.stop) begin
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt >= r_dwell) begin
            r_en    <= 1'b0;
            r_done  <= w_is_last;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + DWELL_W'(1);
          end
        end
        GAP: begin
          if (bus.stop || (w_is_last && !r_cont)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_sel   <= w_is_last ? w_first_sel : w_next_sel;
            r_cnt   <= DWELL_W'(1);
            r_en    <= 1'b1;
            r_state <= DWELL;
          end
        end
        default: begin
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.en         = r_en;
  assign bus.sel        = r_sel;
  assign bus.busy       = r_busy;
  assign bus.sweep_done = r_done;
  assign bus.cfg_err    = r_err;
endmodule

// File: tb/tb_dec_scan_seq.sv
// Directed plus randomized bench; expected outputs come from a per-sweep trace
// queue built from the mask/dwell rules.
module tb_dec_scan_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_scan_seq_if #(.SEL_W(4), .DWELL_W(8)) bus ();
  dec_scan_seq #(.SEL_W(4), .DWELL_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic       en;
    logic [3:0] sel;
    logic       done;
  } ent_t;

  ent_t        q[$];
  logic        m_active = 1'b0;
  logic        m_cont = 1'b0;
  logic [15:0] m_mask = '0;
  int          m_d = 1;
  logic        e_en = 0, e_busy = 0, e_done = 0, e_err = 0;
  logic [3:0]  e_sel = '0;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int last_done_cyc = -1;
  int done_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One full sweep: D cycles of en=1 per set channel, then a gap; done on the top gap.
  task automatic build_sweep();
    int hi;
    hi = 0;
    for (int c = 0; c < 16; c++) if (m_mask[c]) hi = c;
    for (int c = 0; c < 16; c++) begin
      if (m_mask[c]) begin
        for (int k = 0; k < m_d; k++) q.push_back('{1'b1, 4'(c), 1'b0});
        q.push_back('{1'b0, 4'(c), (c == hi)});
      end
    end
  endtask

  task automatic model_edge();
    ent_t e;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (!m_active) begin
      e_en = 1'b0;
      e_busy = 1'b0;
      if (bus.start && !bus.stop) begin
        if (bus.mask == 16'h0) e_err = 1'b1;
        else begin
          m_mask = bus.mask;
          m_d = (bus.dwell == 8'd0) ? 1 : int'(bus.dwell);
          m_cont = bus.continuous;
          q.delete();
          build_sweep();
          m_active = 1'b1;
        end
      end
    end else if (bus.stop) begin
      m_active = 1'b0;
      e_en = 1'b0;
      e_busy = 1'b0;
      q.delete();
    end else if (q.size() == 0) begin
      if (m_cont) build_sweep();
      else begin
        m_active = 1'b0;
        e_en = 1'b0;
        e_busy = 1'b0;
      end
    end
    if (m_active) begin
      e = q.pop_front();
      e_en = e.en;
      e_sel = e.sel;
      e_done = e.done;
      e_busy = 1'b1;
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {24'h0, bus.en, bus.sel, bus.busy, bus.sweep_done, bus.cfg_err};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {24'h0, e_en, e_sel, e_busy, e_done, e_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc_n++;
    if (bus.sweep_done) begin
      last_done_cyc = cyc_n;
      done_count++;
    end
    chk("cycle_outputs", obs_vec(), exp_vec());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    int s0;
    int n;
    bus.start = 0; bus.stop = 0; bus.mask = '0; bus.dwell = '0; bus.continuous = 0;
    #1;
    chk("reset_state", obs_vec(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // Reset mid-dwell at sel=5 must clear outputs before the next edge.
    bus.mask = 16'h0020; bus.dwell = 8'd5; bus.continuous = 1'b1;
    pulse_start();
    run(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_mid_dwell", obs_vec(), 32'h0);
    m_active = 0; q.delete();
    e_en = 0; e_sel = '0; e_busy = 0; e_done = 0; e_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // Full mask, dwell 0, one-shot.
    bus.mask = 16'hFFFF; bus.dwell = 8'd0; bus.continuous = 1'b0;
    s0 = cyc_n + 1;
    pulse_start();
    run(35);
    chk("full_sweep_done_cycle", 32'(last_done_cyc - s0 + 1), 32'(16 * (1 + 1)));

    // Two-channel continuous, then stop during dwell.
    bus.mask = 16'h8001; bus.dwell = 8'd3; bus.continuous = 1'b1;
    pulse_start();
    run(18);
    n = 0;
    while (!e_en && n < 10) begin cyc(); n++; end
    chk("reach_dwell_for_stop", 32'(e_en), 32'd1);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    done_count = 0;
    run(12);
    chk("no_done_after_stop", 32'(done_count), 32'd0);

    // Empty mask start, and start+stop together.
    bus.mask = 16'h0;
    pulse_start();
    run(2);
    bus.mask = 16'h00F0; bus.start = 1'b1; bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    run(2);

    // Single channel continuous: en 1,1,0 with done every third cycle.
    bus.mask = 16'h0010; bus.dwell = 8'd2; bus.continuous = 1'b1;
    done_count = 0;
    pulse_start();
    run(8);
    chk("single_ch_done_count", 32'(done_count), 32'd3);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;

    // Config changes and re-start while busy are ignored.
    bus.mask = 16'h00F0; bus.dwell = 8'd1; bus.continuous = 1'b0;
    pulse_start();
    run(3);
    bus.mask = 16'h0003; bus.dwell = 8'd7; bus.continuous = 1'b1;
    pulse_start();
    run(8);
    chk("snapshot_oneshot_idle", 32'(bus.busy), 32'd0);

    // Randomized sweeps with sporadic start/stop and config churn.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: bus.mask = 16'h1 << $urandom_range(0, 15);
        1: bus.mask = 16'($urandom & $urandom & $urandom);
        default: bus.mask = 16'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) bus.mask = 16'h0;
      bus.dwell = 8'($urandom_range(0, 3));
      bus.continuous = 1'($urandom_range(0, 1));
      pulse_start();
      n = $urandom_range(5, 60);
      for (int k = 0; k < n; k++) begin
        bus.stop  = ($urandom_range(0, 99) < 3);
        bus.start = ($urandom_range(0, 99) < 5);
        if ($urandom_range(0, 9) == 0) bus.mask = 16'($urandom);
        if ($urandom_range(0, 9) == 0) bus.dwell = 8'($urandom_range(0, 4));
        cyc();
      end
      bus.start = 1'b0;
      bus.stop = 1'b1;
      cyc();
      bus.stop = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
